pcm_bus_master: RTL and testbench

// - Sound-side initiator for the PCM ROM interface: drives the multiplexed ADPCM-A (R) and ADPCM-B (P) address buses and

---
 rtl/pcm_bus_master.sv | 244 ++++++++++++++++++++++++
 tb/tb_pcm_bus_master.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pcm_bus_master.sv
// PCM ROM bus initiator: arbitrates two byte-fetch clients onto the multiplexed R (ADPCM-A)
// and P (ADPCM-B) address buses, sequences the address/strobe phases and returns the ROM byte.
module pcm_bus_master #(
   parameter int PHASE_CYC = 2,
   parameter int RD_WAIT   = 4
) (
   input  logic        CLK_8M,
   input  logic        nRESET,
   input  logic        A_REQ,
   input  logic [23:0] A_ADDR,
   output logic        A_ACK,
   output logic [7:0]  A_DATA,
   input  logic        B_REQ,
   input  logic [23:0] B_ADDR,
   output logic        B_ACK,
   output logic [7:0]  B_DATA,
   output logic [7:0]  SDRAD_O,
   output logic        SDRAD_EN,
   input  logic [7:0]  SDRAD_I,
   output logic [1:0]  SDRA_L,
   output logic [3:0]  SDRA_U,
   output logic        SDRMPX,
   output logic        nSDROE,
   output logic [7:0]  SDPAD_O,
   output logic        SDPAD_EN,
   input  logic [7:0]  SDPAD_I,
   output logic [3:0]  SDPA,
   output logic        SDPMPX,
   output logic        nSDPOE,
   output logic [2:0]  dbg_state
);

   localparam int MAX_CYC = (PHASE_CYC > RD_WAIT) ? PHASE_CYC : RD_WAIT;
   localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_LO_SETUP  = 3'd1,
      S_LO_STROBE = 3'd2,
      S_HI_SETUP  = 3'd3,
      S_HI_STROBE = 3'd4,
      S_READ      = 3'd5
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               sel_q, sel_d;     // 0 = client A / R bus, 1 = client B / P bus
   logic               rr_q, rr_d;       // 1 = prefer B when both request
   logic [23:0]        addr_q, addr_d;
   logic               last_cyc;
   logic               grant_b;

   logic               a_ack_q, a_ack_d, b_ack_q, b_ack_d;
   logic [7:0]         a_data_q, a_data_d, b_data_q, b_data_d;
   logic [7:0]         sdrad_o_q, sdrad_o_d, sdpad_o_q, sdpad_o_d;
   logic [1:0]         sdra_l_q, sdra_l_d;
   logic [3:0]         sdra_u_q, sdra_u_d, sdpa_q, sdpa_d;
   logic               sdrad_en_q, sdrad_en_d, sdpad_en_q, sdpad_en_d;
   logic               sdrmpx_q, sdrmpx_d, sdpmpx_q, sdpmpx_d;
   logic               nsdroe_q, nsdroe_d, nsdpoe_q, nsdpoe_d;

   logic [11:0]        bus_v;
   logic               mpx_v, en_v, oe_v;

   // Handshake: a client raises REQ with ADDR stable and holds it until ACK; ACK is a single-clock
   // pulse with DATA valid and held until that client's next ACK. REQ still high in the ACK clock
   // is a fresh request; a REQ dropped after grant still completes and ACKs.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      sel_d    = sel_q;
      rr_d     = rr_q;
      addr_d   = addr_q;
      grant_b  = 1'b0;
      a_ack_d  = 1'b0;
      b_ack_d  = 1'b0;
      a_data_d = a_data_q;
      b_data_d = b_data_q;
      last_cyc = (state_q == S_READ) ? (cnt_q == CNT_W'(RD_WAIT - 1))
                                     : (cnt_q == CNT_W'(PHASE_CYC - 1));

      case (state_q)
         S_IDLE: begin
            if (A_REQ || B_REQ) begin
               grant_b = B_REQ && (!A_REQ || rr_q);
               sel_d   = grant_b;
               rr_d    = !grant_b;
               addr_d  = grant_b ? B_ADDR : A_ADDR;
               state_d = S_LO_SETUP;
               cnt_d   = '0;
            end
         end
         S_LO_SETUP, S_LO_STROBE, S_HI_SETUP, S_HI_STROBE, S_READ: begin
            if (!last_cyc) begin
               cnt_d = cnt_q + CNT_W'(1);
            end else begin
               cnt_d = '0;
               case (state_q)
                  S_LO_SETUP:  state_d = S_LO_STROBE;
                  S_LO_STROBE: state_d = S_HI_SETUP;
                  S_HI_SETUP:  state_d = S_HI_STROBE;
                  S_HI_STROBE: state_d = S_READ;
                  default: begin
                     state_d = S_IDLE;
                     if (sel_q) begin
                        b_ack_d  = 1'b1;
                        b_data_d = SDPAD_I;
                     end else begin
                        a_ack_d  = 1'b1;
                        a_data_d = SDRAD_I;
                     end
                  end
               endcase
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Pad outputs are decoded from the next state and registered, so every pad changes only on a clock edge.
   always_comb begin
      bus_v = '0;
      mpx_v = 1'b0;
      en_v  = 1'b0;
      oe_v  = 1'b0;
      case (state_d)
         S_LO_SETUP: begin
            bus_v = sel_d ? addr_d[11:0] : {2'b00, addr_d[9:0]};
            en_v  = 1'b1;
         end
         S_LO_STROBE: begin
            bus_v = sel_d ? addr_d[11:0] : {2'b00, addr_d[9:0]};
            mpx_v = 1'b1;
            en_v  = 1'b1;
         end
         S_HI_SETUP: begin
            bus_v = sel_d ? addr_d[23:12] : {2'b00, addr_d[19:10]};
            mpx_v = 1'b1;
            en_v  = 1'b1;
         end
         S_HI_STROBE: begin
            bus_v = sel_d ? addr_d[23:12] : {2'b00, addr_d[19:10]};
            en_v  = 1'b1;
         end
         S_READ:  oe_v = 1'b1;
         default: oe_v = 1'b0;
      endcase

      sdrad_o_d  = '0;
      sdra_l_d   = '0;
      sdra_u_d   = '0;
      sdrmpx_d   = 1'b0;
      sdrad_en_d = 1'b0;
      nsdroe_d   = 1'b1;
      sdpad_o_d  = '0;
      sdpa_d     = '0;
      sdpmpx_d   = 1'b0;
      sdpad_en_d = 1'b0;
      nsdpoe_d   = 1'b1;
      if (state_d != S_IDLE) begin
         if (sel_d) begin
            sdpad_o_d  = bus_v[7:0];
            sdpa_d     = bus_v[11:8];
            sdpmpx_d   = mpx_v;
            sdpad_en_d = en_v;
            nsdpoe_d   = !oe_v;
         end else begin
            sdrad_o_d  = bus_v[7:0];
            sdra_l_d   = bus_v[9:8];
            sdra_u_d   = addr_d[23:20];
            sdrmpx_d   = mpx_v;
            sdrad_en_d = en_v;
            nsdroe_d   = !oe_v;
         end
      end
   end

   always_ff @(posedge CLK_8M or negedge nRESET) begin
      if (!nRESET) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         sel_q      <= 1'b0;
         rr_q       <= 1'b0;
         addr_q     <= '0;
         a_ack_q    <= 1'b0;
         b_ack_q    <= 1'b0;
         a_data_q   <= '0;
         b_data_q   <= '0;
         sdrad_o_q  <= '0;
         sdra_l_q   <= '0;
         sdra_u_q   <= '0;
         sdrmpx_q   <= 1'b0;
         sdrad_en_q <= 1'b0;
         nsdroe_q   <= 1'b1;
         sdpad_o_q  <= '0;
         sdpa_q     <= '0;
         sdpmpx_q   <= 1'b0;
         sdpad_en_q <= 1'b0;
         nsdpoe_q   <= 1'b1;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         sel_q      <= sel_d;
         rr_q       <= rr_d;
         addr_q     <= addr_d;
         a_ack_q    <= a_ack_d;
         b_ack_q    <= b_ack_d;
         a_data_q   <= a_data_d;
         b_data_q   <= b_data_d;
         sdrad_o_q  <= sdrad_o_d;
         sdra_l_q   <= sdra_l_d;
         sdra_u_q   <= sdra_u_d;
         sdrmpx_q   <= sdrmpx_d;
         sdrad_en_q <= sdrad_en_d;
         nsdroe_q   <= nsdroe_d;
         sdpad_o_q  <= sdpad_o_d;
         sdpa_q     <= sdpa_d;
         sdpmpx_q   <= sdpmpx_d;
         sdpad_en_q <= sdpad_en_d;
         nsdpoe_q   <= nsdpoe_d;
      end
   end

   assign A_ACK     = a_ack_q;
   assign A_DATA    = a_data_q;
   assign B_ACK     = b_ack_q;
   assign B_DATA    = b_data_q;
   assign SDRAD_O   = sdrad_o_q;
   assign SDRAD_EN  = sdrad_en_q;
   assign SDRA_L    = sdra_l_q;
   assign SDRA_U    = sdra_u_q;
   assign SDRMPX    = sdrmpx_q;
   assign nSDROE    = nsdroe_q;
   assign SDPAD_O   = sdpad_o_q;
   assign SDPAD_EN  = sdpad_en_q;
   assign SDPA      = sdpa_q;
   assign SDPMPX    = sdpmpx_q;
   assign nSDPOE    = nsdpoe_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_pcm_bus_master.sv
// Directed bench for pcm_bus_master: default-timing instance plus a PHASE_CYC=1/RD_WAIT=1 instance.
module tb_pcm_bus_master;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // ---------------- default instance ----------------
   logic        a_req = 0, b_req = 0;
   logic [23:0] a_addr = '0, b_addr = '0;
   logic [7:0]  sdrad_i = '0, sdpad_i = '0;
   logic        A_ACK, B_ACK, SDRAD_EN, SDRMPX, nSDROE, SDPAD_EN, SDPMPX, nSDPOE;
   logic [7:0]  A_DATA, B_DATA, SDRAD_O, SDPAD_O;
   logic [1:0]  SDRA_L;
   logic [3:0]  SDRA_U, SDPA;
   logic [2:0]  dbg_state;

   pcm_bus_master u_dut (
      .CLK_8M(clk), .nRESET(rst_n),
      .A_REQ(a_req), .A_ADDR(a_addr), .A_ACK(A_ACK), .A_DATA(A_DATA),
      .B_REQ(b_req), .B_ADDR(b_addr), .B_ACK(B_ACK), .B_DATA(B_DATA),
      .SDRAD_O(SDRAD_O), .SDRAD_EN(SDRAD_EN), .SDRAD_I(sdrad_i), .SDRA_L(SDRA_L), .SDRA_U(SDRA_U),
      .SDRMPX(SDRMPX), .nSDROE(nSDROE),
      .SDPAD_O(SDPAD_O), .SDPAD_EN(SDPAD_EN), .SDPAD_I(sdpad_i), .SDPA(SDPA),
      .SDPMPX(SDPMPX), .nSDPOE(nSDPOE), .dbg_state(dbg_state)
   );

   // ---------------- fast instance ----------------
   logic        f_a_req = 0;
   logic [23:0] f_a_addr = '0;
   logic [7:0]  f_sdrad_i = '0;
   logic        f_A_ACK, f_B_ACK, f_SDRAD_EN, f_SDRMPX, f_nSDROE, f_SDPAD_EN, f_SDPMPX, f_nSDPOE;
   logic [7:0]  f_A_DATA, f_B_DATA, f_SDRAD_O, f_SDPAD_O;
   logic [1:0]  f_SDRA_L;
   logic [3:0]  f_SDRA_U, f_SDPA;
   logic [2:0]  f_dbg_state;

   pcm_bus_master #(.PHASE_CYC(1), .RD_WAIT(1)) u_fast (
      .CLK_8M(clk), .nRESET(rst_n),
      .A_REQ(f_a_req), .A_ADDR(f_a_addr), .A_ACK(f_A_ACK), .A_DATA(f_A_DATA),
      .B_REQ(1'b0), .B_ADDR(24'h0), .B_ACK(f_B_ACK), .B_DATA(f_B_DATA),
      .SDRAD_O(f_SDRAD_O), .SDRAD_EN(f_SDRAD_EN), .SDRAD_I(f_sdrad_i), .SDRA_L(f_SDRA_L), .SDRA_U(f_SDRA_U),
      .SDRMPX(f_SDRMPX), .nSDROE(f_nSDROE),
      .SDPAD_O(f_SDPAD_O), .SDPAD_EN(f_SDPAD_EN), .SDPAD_I(8'h00), .SDPA(f_SDPA),
      .SDPMPX(f_SDPMPX), .nSDPOE(f_nSDPOE), .dbg_state(f_dbg_state)
   );

   // ---------------- bus monitor ----------------
   logic [11:0] r_bus, p_bus, r_prev, p_prev;
   logic        r_mpx_prev, p_mpx_prev;
   logic [49:0] out_vec, out_prev;
   logic [11:0] r_lo_cap, r_hi_cap, p_lo_cap, p_hi_cap;
   logic [3:0]  r_u_cap;
   int          r_oe_cnt, p_oe_cnt, viol_cnt, stable_err, toggles, a_ack_cnt, b_ack_cnt;
   logic        ack_order[$];

   assign r_bus   = {2'b00, SDRA_L, SDRAD_O};
   assign p_bus   = {SDPA, SDPAD_O};
   assign out_vec = {A_ACK, A_DATA, B_ACK, B_DATA, SDRAD_O, SDRAD_EN, SDRA_L, SDRA_U, SDRMPX, nSDROE,
                     SDPAD_O, SDPAD_EN, SDPA, SDPMPX, nSDPOE};

   initial begin
      r_prev = '0; p_prev = '0; r_mpx_prev = 0; p_mpx_prev = 0; out_prev = '0;
      r_lo_cap = '0; r_hi_cap = '0; p_lo_cap = '0; p_hi_cap = '0; r_u_cap = '0;
      r_oe_cnt = 0; p_oe_cnt = 0; viol_cnt = 0; stable_err = 0; toggles = 0;
      a_ack_cnt = 0; b_ack_cnt = 0;
   end

   always @(negedge clk) begin
      if (SDRMPX && !r_mpx_prev) begin r_lo_cap = r_bus; if (r_bus != r_prev) stable_err++; end
      if (!SDRMPX && r_mpx_prev) begin r_hi_cap = r_bus; if (r_bus != r_prev) stable_err++; end
      if (SDPMPX && !p_mpx_prev) begin p_lo_cap = p_bus; if (p_bus != p_prev) stable_err++; end
      if (!SDPMPX && p_mpx_prev) begin p_hi_cap = p_bus; if (p_bus != p_prev) stable_err++; end
      if (!nSDROE) begin r_oe_cnt++; r_u_cap = SDRA_U; end
      if (!nSDPOE) p_oe_cnt++;
      if (!nSDROE && !nSDPOE) viol_cnt++;
      if ((SDRAD_EN && !nSDROE) || (SDPAD_EN && !nSDPOE)) viol_cnt++;
      if ((A_ACK || B_ACK) && (SDRAD_EN || SDPAD_EN || !nSDROE || !nSDPOE)) viol_cnt++;
      if (A_ACK) begin a_ack_cnt++; ack_order.push_back(1'b0); end
      if (B_ACK) begin b_ack_cnt++; ack_order.push_back(1'b1); end
      if (out_vec != out_prev) toggles++;
      r_prev = r_bus; p_prev = p_bus; r_mpx_prev = SDRMPX; p_mpx_prev = SDPMPX; out_prev = out_vec;
   end

   // ---------------- scoreboard / checking ----------------
   logic [7:0] exp_q[$];
   int n_total = 0;
   int n_pass  = 0;
   localparam logic [49:0] RST_VEC = {1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 2'b00, 4'h0, 1'b0, 1'b1,
                                      8'h00, 1'b0, 4'h0, 1'b0, 1'b1};

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
   endtask

   // ---------------- driver ----------------
   task automatic do_fetch(input bit is_b, input logic [23:0] addr, input logic [7:0] din,
                           input bit drop_early, output int lat);
      bit done;
      done = 0;
      lat  = -1;
      r_lo_cap = '0; r_hi_cap = '0; p_lo_cap = '0; p_hi_cap = '0; r_u_cap = '0;
      r_oe_cnt = 0; p_oe_cnt = 0;
      exp_q.push_back(din);
      if (is_b) begin b_addr = addr; sdpad_i = din; b_req = 1; end
      else      begin a_addr = addr; sdrad_i = din; a_req = 1; end
      for (int c = 1; c <= 60 && !done; c++) begin
         @(negedge clk);
         if (c == 2) begin
            // scramble the address after grant; the captured copy must be used
            if (is_b) begin b_addr = ~addr; if (drop_early) b_req = 0; end
            else      begin a_addr = ~addr; if (drop_early) a_req = 0; end
         end
         if (is_b ? B_ACK : A_ACK) begin
            done = 1;
            lat  = c - 1;
            if (is_b) b_req = 0; else a_req = 0;
            check(is_b ? "b_data" : "a_data", is_b ? B_DATA : A_DATA, exp_q.pop_front());
         end
      end
      check("ack_seen", done, 1);
      if (!done) begin a_req = 0; b_req = 0; if (exp_q.size() > 0) void'(exp_q.pop_front()); end
      #1;
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int  lat;
      int  acks_before;
      bit  seen;
      logic [3:0] order;

      // reset state
      repeat (3) @(negedge clk);
      #1;
      check("rst_outputs", out_vec, RST_VEC);
      check("rst_state", dbg_state, 3'd0);
      check("rst_fast_oe", {f_nSDROE, f_SDRMPX, f_SDRAD_EN, f_A_ACK}, 4'b1000);
      @(negedge clk);
      rst_n = 1;

      // quiet bus with no requests
      @(negedge clk);
      toggles = 0;
      repeat (20) @(negedge clk);
      #1;
      check("idle_toggles", toggles, 0);
      check("idle_outputs", out_vec, RST_VEC);

      // client A fetch on R bus
      do_fetch(0, 24'hA5_3C7E, 8'h9D, 0, lat);
      check("a_latency", lat, 12);
      check("a_lo", r_lo_cap, 12'h07E);
      check("a_hi", r_hi_cap, 12'h14F);
      check("a_upper", r_u_cap, 4'hA);
      check("a_oe_cycles", r_oe_cnt, 4);
      check("a_p_oe_quiet", p_oe_cnt, 0);

      // client B fetch on P bus, REQ dropped after grant
      repeat (2) @(negedge clk);
      do_fetch(1, 24'h12_3456, 8'hE1, 1, lat);
      check("b_latency", lat, 12);
      check("b_lo", p_lo_cap, 12'h456);
      check("b_hi", p_hi_cap, 12'h123);
      check("b_oe_cycles", p_oe_cnt, 4);
      check("b_r_oe_quiet", r_oe_cnt, 0);
      check("b_ack_count", b_ack_cnt, 1);

      // both clients held: grants alternate
      repeat (2) @(negedge clk);
      ack_order.delete();
      a_addr = 24'h00_0155; b_addr = 24'h00_0AAA; sdrad_i = 8'h11; sdpad_i = 8'h22;
      a_req = 1; b_req = 1;
      for (int c = 0; c < 200 && ack_order.size() < 4; c++) @(negedge clk);
      a_req = 0; b_req = 0;
      repeat (2) @(negedge clk);
      #1;
      check("alt_count", ack_order.size(), 4);
      order = 4'hF;
      for (int i = 0; i < 4 && i < ack_order.size(); i++) order[i] = ack_order[i];
      check("alt_order", order, 4'b1010);
      check("alt_a_data", A_DATA, 8'h11);
      check("alt_b_data", B_DATA, 8'h22);
      check("bus_violations", viol_cnt, 0);
      check("strobe_stability", stable_err, 0);

      // reset pulsed during READ of an A fetch
      acks_before = a_ack_cnt;
      a_addr = 24'h77_7777; sdrad_i = 8'hCC; a_req = 1;
      seen = 0;
      for (int c = 0; c < 40 && !seen; c++) begin
         @(negedge clk);
         if (!nSDROE) seen = 1;
      end
      check("abort_read_seen", seen, 1);
      @(negedge clk);
      rst_n = 0;
      #1;
      check("abort_outputs", out_vec, {1'b0, A_DATA, 1'b0, B_DATA, 8'h00, 1'b0, 2'b00, 4'h0, 1'b0, 1'b1,
                                       8'h00, 1'b0, 4'h0, 1'b0, 1'b1});
      check("abort_data_cleared", {A_DATA, B_DATA}, 16'h0000);
      check("abort_state", dbg_state, 3'd0);
      a_req = 0;
      repeat (3) @(negedge clk);
      #1;
      check("abort_no_ack", a_ack_cnt, acks_before);
      rst_n = 1;
      @(negedge clk);
      do_fetch(0, 24'h3F_0201, 8'h5A, 0, lat);
      check("post_rst_latency", lat, 12);
      check("post_rst_lo", r_lo_cap, 12'h201);
      check("post_rst_hi", r_hi_cap, 12'h3C0);
      check("post_rst_upper", r_u_cap, 4'h3);
      check("final_violations", viol_cnt, 0);

      // PHASE_CYC=1, RD_WAIT=1 instance: one clock per phase, ACK five clocks after grant
      f_a_addr = 24'hA5_3C7E; f_sdrad_i = 8'h3C; f_a_req = 1;
      @(negedge clk);
      check("fast_lo_setup",  {f_SDRMPX, f_SDRAD_EN, f_SDRA_L, f_SDRAD_O}, {1'b0, 1'b1, 10'h07E});
      @(negedge clk);
      check("fast_lo_strobe", {f_SDRMPX, f_SDRAD_EN, f_SDRA_L, f_SDRAD_O}, {1'b1, 1'b1, 10'h07E});
      @(negedge clk);
      check("fast_hi_setup",  {f_SDRMPX, f_SDRAD_EN, f_SDRA_L, f_SDRAD_O}, {1'b1, 1'b1, 10'h14F});
      @(negedge clk);
      check("fast_hi_strobe", {f_SDRMPX, f_SDRAD_EN, f_SDRA_L, f_SDRAD_O}, {1'b0, 1'b1, 10'h14F});
      @(negedge clk);
      check("fast_read", {f_nSDROE, f_SDRAD_EN, f_A_ACK, f_SDRA_U}, {1'b0, 1'b0, 1'b0, 4'hA});
      @(negedge clk);
      check("fast_ack", {f_A_ACK, f_A_DATA, f_nSDROE}, {1'b1, 8'h3C, 1'b1});
      f_a_req = 0;
      @(negedge clk);
      check("fast_ack_pulse", f_A_ACK, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
